frame_seq_ctrl: RTL
===================

FRAME_SEQ_CTRL -- requirements
Module: frame_seq_ctrl

Interface
REQ-001 Parameter H_DISP, default 640: required active pixels per line.
REQ-002 Parameter V_DISP, default 480: required active lines per frame.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a capture run.
REQ-006 abort  input  1  single-cycle request to cancel the current run.
REQ-007 frame_num  input  8  frames to process, sampled only when start is accepted.
REQ-008 in_vsync  input  1  timing-source frame sync; low during sync pulse.
REQ-009 in_de  input  1  timing-source active-pixel enable.
REQ-010 filt_en  output  1  datapath enable; equals in_de AND (state==ACTIVE), combinational.
REQ-011 out_sof  output  1  one-cycle pulse at start of each processed frame.
REQ-012 out_eof  output  1  one-cycle pulse at end of each processed frame.
REQ-013 frame_cnt  output  8  frames completed in the current run.
REQ-014 line_cnt  output  16  lines completed in the current frame.
REQ-015 busy  output  1  high in WAIT_SOF and ACTIVE.
REQ-016 done  output  1  one-cycle pulse on run completion.
REQ-017 err  output  1  sticky error flag.
REQ-018 err_code  output  2  first error: 01 = line length, 10 = frame height, 00 = none.

Function
REQ-019 SOF SHALL be detected as in_vsync rising edge (registered previous in_vsync = 0, current = 1); EOL as in_de falling edge (previous = 1, current = 0).
REQ-020 States SHALL be IDLE, WAIT_SOF, ACTIVE, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-021 IDLE: start with frame_num != 0 -> WAIT_SOF, clear frame_cnt, line_cnt, pixel count, err, err_code; latch frame_num.
REQ-022 IDLE: start with frame_num == 0 -> DONE with no frame processed.
REQ-023 start SHALL be ignored in WAIT_SOF, ACTIVE and DONE.
REQ-024 WAIT_SOF: on SOF -> ACTIVE, pulse out_sof same cycle as registered transition output (one cycle after SOF detect), clear line_cnt and pixel count.
REQ-025 ACTIVE: each cycle with in_de = 1 SHALL increment a 16-bit pixel count, saturating at 0xFFFF.
REQ-026 ACTIVE EOL: if pixel count != H_DISP and err_code == 00, set err = 1, err_code = 01; increment line_cnt (saturating); clear pixel count.
REQ-027 ACTIVE SOF: if line_cnt != V_DISP and err_code == 00, set err = 1, err_code = 10; pulse out_eof; increment frame_cnt.
REQ-028 ACTIVE SOF with frame_cnt+1 == latched frame_num -> DONE; otherwise remain ACTIVE, pulse out_sof, clear line_cnt and pixel count.
REQ-029 in_de = 1 on the same cycle as an SOF SHALL count toward the new frame.
REQ-030 Errors SHALL NOT stop the run; only the first error is recorded in err_code.
REQ-031 abort in WAIT_SOF or ACTIVE SHALL force IDLE next cycle; no done, no out_eof; abort has priority over SOF, EOL and start.
REQ-032 done SHALL pulse for the single cycle spent in DONE; busy SHALL be 0 in DONE.
REQ-033 err and err_code SHALL hold after run end until the next accepted start or reset.

Reset
REQ-034 Asserting rst_n low SHALL immediately force state IDLE and all outputs 0 (filt_en, out_sof, out_eof, frame_cnt, line_cnt, busy, done, err, err_code), including mid-run.
REQ-035 Registered previous in_vsync SHALL reset to 1 and previous in_de to 0, so no SOF/EOL fires on the first cycle after reset release.

Verification (H_DISP=4, V_DISP=3 bench timing)
REQ-036 start, frame_num=2, clean 4x3 frames -> two out_sof, two out_eof, frame_cnt=2, single done pulse after third SOF, err=0.
REQ-037 One line with 3 DE cycles in frame 1 -> err=1, err_code=01, run still completes with done, frame_cnt=2.
REQ-038 Frame with 2 lines, later line of 5 pixels -> err_code=10 from frame-height check only if first; first-error rule holds.
REQ-039 abort mid ACTIVE -> IDLE next cycle, busy=0, filt_en=0, no done, no out_eof.
REQ-040 start with frame_num=0 -> done one cycle later, busy never 1; start while busy -> ignored, frame_num not relatched.
REQ-041 rst_n low during ACTIVE -> all outputs 0 asynchronously; after release no spurious out_sof until a real in_vsync rising edge plus start.

Source files
------------

// File: rtl/frame_seq_ctrl.sv
// ============================================================================
//  Module   : frame_seq_ctrl
//  Brief    : Frame capture sequencer with line/frame geometry checking.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module frame_seq_ctrl #(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  frame_num,
  input  logic        in_vsync,
  input  logic        in_de,
  output logic        filt_en,
  output logic        out_sof,
  output logic        out_eof,
  output logic [7:0]  frame_cnt,
  output logic [15:0] line_cnt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state;
  logic        vsync_q;
  logic        de_q;
  logic [7:0]  frames_lat;
  logic [15:0] pix_cnt;

  logic        sof;
  logic        eol;
  logic [15:0] pix_inc;
  logic [15:0] line_inc;
  logic [15:0] line_next;
  logic [7:0]  frame_inc;
  logic        line_err;
  logic        frame_err;
  logic        last_frame;
  logic [15:0] pix_start;

  assign sof = ~vsync_q & in_vsync;
  assign eol = de_q & ~in_de;

  assign pix_inc   = (pix_cnt == 16'hFFFF) ? pix_cnt : pix_cnt + 16'd1;
  assign line_inc  = (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;
  assign frame_inc = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
  assign line_next = eol ? line_inc : line_cnt;

  // A line error on the same cycle outranks the frame-height check.
  assign line_err   = eol && (pix_cnt != 16'(H_DISP)) && (err_code == 2'b00);
  assign frame_err  = sof && (line_next != 16'(V_DISP)) && (err_code == 2'b00) && !line_err;
  assign last_frame = (frame_inc == frames_lat);

  // DE coincident with SOF already belongs to the new frame.
  assign pix_start = in_de ? 16'd1 : 16'd0;

  assign filt_en = in_de && (state == ACTIVE);
  assign busy    = (state == WAIT_SOF) || (state == ACTIVE);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vsync_q    <= 1'b1;
      de_q       <= 1'b0;
      frames_lat <= 8'd0;
      pix_cnt    <= 16'd0;
      frame_cnt  <= 8'd0;
      line_cnt   <= 16'd0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      vsync_q <= in_vsync;
      de_q    <= in_de;
      out_sof <= 1'b0;
      out_eof <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (frame_num != 8'd0) begin
              state      <= WAIT_SOF;
              frames_lat <= frame_num;
              frame_cnt  <= 8'd0;
              line_cnt   <= 16'd0;
              pix_cnt    <= 16'd0;
              err        <= 1'b0;
              err_code   <= 2'b00;
            end else begin
              state <= DONE;
            end
          end
        end

        WAIT_SOF: begin
          if (abort) begin
            state <= IDLE;
          end else if (sof) begin
            state    <= ACTIVE;
            out_sof  <= 1'b1;
            line_cnt <= 16'd0;
            pix_cnt  <= pix_start;
          end
        end

        ACTIVE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            if (line_err) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end else if (frame_err) begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end

            if (sof) begin
              out_eof   <= 1'b1;
              frame_cnt <= frame_inc;
              if (last_frame) begin
                state    <= DONE;
                line_cnt <= line_next;
              end else begin
                out_sof  <= 1'b1;
                line_cnt <= 16'd0;
                pix_cnt  <= pix_start;
              end
            end else if (eol) begin
              line_cnt <= line_inc;
              pix_cnt  <= 16'd0;
            end else if (in_de) begin
              pix_cnt <= pix_inc;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
